intpol2_iq_out_buffer: RTL and testbench
========================================

# intpol2_iq_out_buffer

Output buffer directly downstream of the intpol2 IQ interpolation core. It captures each interpolated I/Q pair strobed by the core's write enable and holds pairs in a shared-pointer ring. It returns an almost-full flag that feeds the core's Afull input, and delivers samples on a valid/ready stream, narrowed from DATA_WIDTH to OUT_WIDTH. It also keeps a sticky overflow flag and a delivered-sample counter.

## Interface
- DATA_WIDTH, 32, input I/Q sample width (core output format, 2 integer bits)
- OUT_WIDTH, 16, output sample width; must be ≤ DATA_WIDTH
- ADDR_WIDTH, 3, ring address bits; DEPTH = 2^ADDR_WIDTH
- AF_DIFF, 2, almost-full margin in entries
- clk  in  1  single clock, posedge
- rst_a  in  1  asynchronous, active-low reset
- clr_i  in  1  synchronous flush, active high
- wr_en_i  in  1  sample strobe from the core's Write_Enable_o
- I_in_i  in  DATA_WIDTH  interpolated I
- Q_in_i  in  DATA_WIDTH  interpolated Q
- afull_o  out  1  ring_count ≥ DEPTH−AF_DIFF; drives the core's Afull input
- full_o  out  1  ring_count == DEPTH
- empty_o  out  1  ring_count == 0 and output register empty
- m_valid_o  out  1  output pair valid
- m_ready_i  in  1  consumer ready
- m_I_o  out  OUT_WIDTH  output I
- m_Q_o  out  OUT_WIDTH  output Q
- count_o  out  ADDR_WIDTH+1  ring occupancy; excludes the output register
- ovf_o  out  1  sticky: a write was dropped
- samples_o  out  32  handshakes completed; wraps 0xFFFFFFFF→0

## Operation
- Storage: DEPTH-entry ring holding {I,Q}, full DATA_WIDTH each. There is one write pointer and one read pointer of ADDR_WIDTH bits; both wrap modulo DEPTH.
- Accepting a write:
  - A write is accepted when wr_en_i=1, ring not full and clr_i=0.
  - An accepted write stores at the write pointer and the pointer advances.
- Dropping a write:
  - A write with wr_en_i=1 while full is dropped.
  - A dropped write sets ovf_o and leaves the ring unchanged.
- Output register:
  - It loads from the read pointer when the ring is non-empty and the register is empty or handshaking (m_valid_o & m_ready_i) that cycle.
  - On load the read pointer advances and the narrowing rule is applied.
- A handshake with no ring data clears m_valid_o.
- Each handshake increments samples_o.
- Simultaneous accepted write and ring pop in the same cycle: count_o unchanged.
- clr_i has priority over everything:
  - It resets pointers, count_o, m_valid_o, ovf_o and samples_o.
  - Any same-cycle write is discarded and does not set ovf_o.
- Narrowing without the macro: take the top bits, out = x[DATA_WIDTH−1 -: OUT_WIDTH]. This is truncation toward −∞, two's complement.
- If OUT_WIDTH == DATA_WIDTH the sample passes through unchanged, with or without the macro.

## Timing
- Reset (rst_a=0, asynchronous):
  - All outputs 0, except empty_o=1.
  - Pointers and count at 0.
  - The contents of the output register are discarded.
- Write latency: a sample written at edge N into an empty buffer is loaded into the output register at edge N+1. m_valid_o=1 after edge N+1.
- Flags timing:
  - afull_o, full_o and empty_o are decoded from registered state, so there is no combinational path from wr_en_i.
  - afull_o rises after the edge that makes ring_count reach DEPTH−AF_DIFF.
- Output stability: m_I_o and m_Q_o hold stable while m_valid_o=1 and m_ready_i=0.
- Throughput: one pair per cycle sustained when m_ready_i=1.
- Reset mid-burst: all in-flight data is lost and there is no spurious m_valid_o after release.

## Configuration
- INTPOL2_OUTBUF_ROUND_EN defined:
  - Narrowing is round-half-up then saturate: y = (x + 2^(DATA_WIDTH−OUT_WIDTH−1)) >> (DATA_WIDTH−OUT_WIDTH), computed with one guard bit.
  - If the result exceeds the OUT_WIDTH signed range it clamps to 0x7FFF… or 0x8000….
  - Adds no latency; the rounding is done combinationally at register load.
- INTPOL2_OUTBUF_ROUND_EN undefined: truncation as in Operation; no adder is instantiated.

## Test plan
Defaults: DATA_WIDTH=32, OUT_WIDTH=16, ADDR_WIDTH=3, AF_DIFF=2.
- Reset: assert rst_a=0 mid-operation -> all outputs 0 and empty_o=1 immediately; after release, no m_valid_o until a new write.
- Narrowing, single write with m_ready_i=1, then check m_valid_o after 2 edges:
  - I=0x1234C000 -> m_I_o=0x1234 truncated, 0x1235 rounded.
  - Q=0x7FFF8000 -> 0x7FFF in both modes (saturated when rounded).
  - Q=0xFFFF8000 -> 0xFFFF truncated, 0x0000 rounded.
- Fill and overflow: m_ready_i=0, 10 consecutive writes:
  - Sample 0 lands in the output register.
  - afull_o=1 after the 7th edge (ring_count=6).
  - full_o=1 and count_o=8 after the 9th edge.
  - The 10th write is dropped and ovf_o=1.
  - Draining yields samples 0–8 in order.
- Streaming: m_ready_i=1, writes every cycle for 100 cycles -> count_o ≤ 1, no gaps after the first output, samples_o=99 at end (the last sample is still in flight).
- Clear collision: clr_i=1 with wr_en_i=1 while full with ovf_o=1 -> next cycle count_o=0, ovf_o=0, samples_o=0, m_valid_o=0, and the write is not stored.
- Ready backpressure: toggle m_ready_i each cycle during a 20-sample burst -> no data loss or duplication, and outputs hold while stalled.

Source files
------------

// File: rtl/intpol2_iq_out_buffer_if.sv
// ---------------------------------------------------------------------------
// intpol2_iq_out_buffer_if
// Valid/ready output stream of the intpol2 IQ output buffer.
//   m_valid_o  : output pair valid (driven by the buffer)
//   m_ready_i  : consumer ready (driven by the consumer)
//   m_I_o      : narrowed I sample, OUT_WIDTH bits
//   m_Q_o      : narrowed Q sample, OUT_WIDTH bits
// Modports: master = buffer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface intpol2_iq_out_buffer_if #(
    parameter int OUT_WIDTH = 16
);
    logic                 m_valid_o;
    logic                 m_ready_i;
    logic [OUT_WIDTH-1:0] m_I_o;
    logic [OUT_WIDTH-1:0] m_Q_o;

    modport master (output m_valid_o, output m_I_o, output m_Q_o, input m_ready_i);
    modport slave  (input m_valid_o, input m_I_o, input m_Q_o, output m_ready_i);
endinterface

// File: rtl/intpol2_iq_out_buffer.sv
// ---------------------------------------------------------------------------
// intpol2_iq_out_buffer
// Captures I/Q pairs strobed by the intpol2 interpolation core into a
// DEPTH = 2^ADDR_WIDTH entry ring, feeds back an almost-full flag for the
// core's Afull input and streams pairs out on a valid/ready interface,
// narrowed from DATA_WIDTH to OUT_WIDTH bits.
//
// Ports:
//   clk        : clock, rising edge
//   rst_a      : asynchronous reset, active low
//   clr_i      : synchronous flush, active high, highest priority
//   wr_en_i    : sample strobe from the core
//   I_in_i     : interpolated I, DATA_WIDTH bits
//   Q_in_i     : interpolated Q, DATA_WIDTH bits
//   afull_o    : ring occupancy >= DEPTH - AF_DIFF
//   full_o     : ring occupancy == DEPTH
//   empty_o    : ring empty and output register empty
//   count_o    : ring occupancy (output register not included)
//   ovf_o      : sticky, a write arrived while full and was dropped
//   samples_o  : completed output handshakes, wraps at 2^32
//   m_if       : output stream (intpol2_iq_out_buffer_if, master modport)
//
// Build option INTPOL2_OUTBUF_ROUND_EN: when defined, narrowing rounds half
// up and saturates; when undefined, narrowing truncates (keeps the top bits).
// ---------------------------------------------------------------------------
module intpol2_iq_out_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_DIFF    = 2
) (
    input  logic                       clk,
    input  logic                       rst_a,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [DATA_WIDTH-1:0]      I_in_i,
    input  logic [DATA_WIDTH-1:0]      Q_in_i,
    output logic                       afull_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [ADDR_WIDTH:0]        count_o,
    output logic                       ovf_o,
    output logic [31:0]                samples_o,
    intpol2_iq_out_buffer_if.master    m_if
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam int                SHIFT    = DATA_WIDTH - OUT_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(DEPTH - AF_DIFF);
`ifdef INTPOL2_OUTBUF_ROUND_EN
    localparam int                RSH      = (SHIFT > 0) ? SHIFT : 1;
`endif

    // Narrowing applied as a sample moves from the ring into the output
    // register, so it adds no latency.
    function automatic logic [OUT_WIDTH-1:0] narrow(input logic [DATA_WIDTH-1:0] x);
`ifdef INTPOL2_OUTBUF_ROUND_EN
        logic [DATA_WIDTH:0] sum;
        logic [OUT_WIDTH:0]  rounded;
        if (SHIFT == 0) begin
            narrow = x[DATA_WIDTH-1 -: OUT_WIDTH];
        end else begin
            // One guard bit above the sign keeps the +half from wrapping;
            // a disagreement between guard and sign means out of range.
            sum     = {x[DATA_WIDTH-1], x} + ((DATA_WIDTH+1)'(1) << (RSH-1));
            rounded = (OUT_WIDTH+1)'($signed(sum) >>> RSH);
            if (rounded[OUT_WIDTH] != rounded[OUT_WIDTH-1])
                narrow = rounded[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            else
                narrow = rounded[OUT_WIDTH-1:0];
        end
`else
        narrow = OUT_WIDTH'(x >> SHIFT);
`endif
    endfunction

    logic [DATA_WIDTH-1:0] r_memI [DEPTH];
    logic [DATA_WIDTH-1:0] r_memQ [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wrPtr;
    logic [ADDR_WIDTH-1:0] r_rdPtr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_valid;
    logic [OUT_WIDTH-1:0]  r_outI;
    logic [OUT_WIDTH-1:0]  r_outQ;
    logic                  r_ovf;
    logic [31:0]           r_samples;

    logic w_full;
    logic w_ringEmpty;
    logic w_hs;
    logic w_wrAccept;
    logic w_wrDrop;
    logic w_load;

    // All decisions come from registered state, so the flags have no
    // combinational path from wr_en_i and a write is only visible to the
    // output register one edge after it lands in the ring.
    assign w_full      = (r_count == DEPTH_L);
    assign w_ringEmpty = (r_count == '0);
    assign w_hs        = r_valid & m_if.m_ready_i;
    assign w_wrAccept  = wr_en_i & ~w_full & ~clr_i;
    assign w_wrDrop    = wr_en_i &  w_full & ~clr_i;
    assign w_load      = ~w_ringEmpty & (~r_valid | w_hs) & ~clr_i;

    // Ring storage carries no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_memI[r_wrPtr] <= I_in_i;
            r_memQ[r_wrPtr] <= Q_in_i;
        end
    end

    // Pointers, occupancy, output register and status counters.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_outI    <= '0;
            r_outQ    <= '0;
            r_ovf     <= 1'b0;
            r_samples <= '0;
        end else if (clr_i) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_samples <= '0;
        end else begin
            if (w_wrAccept)
                r_wrPtr <= r_wrPtr + ADDR_WIDTH'(1);
            if (w_load)
                r_rdPtr <= r_rdPtr + ADDR_WIDTH'(1);
            r_count <= r_count + (ADDR_WIDTH+1)'(w_wrAccept) - (ADDR_WIDTH+1)'(w_load);
            if (w_load) begin
                r_valid <= 1'b1;
                r_outI  <= narrow(r_memI[r_rdPtr]);
                r_outQ  <= narrow(r_memQ[r_rdPtr]);
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_wrDrop)
                r_ovf <= 1'b1;
            if (w_hs)
                r_samples <= r_samples + 32'd1;
        end
    end

    assign afull_o        = (r_count >= AF_LEVEL);
    assign full_o         = w_full;
    assign empty_o        = w_ringEmpty & ~r_valid;
    assign count_o        = r_count;
    assign ovf_o          = r_ovf;
    assign samples_o      = r_samples;
    assign m_if.m_valid_o = r_valid;
    assign m_if.m_I_o     = r_outI;
    assign m_if.m_Q_o     = r_outQ;

endmodule

// File: tb/tb_intpol2_iq_out_buffer.sv
// ---------------------------------------------------------------------------
// tb_intpol2_iq_out_buffer
// Directed self-checking bench for intpol2_iq_out_buffer with default
// parameters (DATA_WIDTH=32, OUT_WIDTH=16, ADDR_WIDTH=3, AF_DIFF=2).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected narrowing values follow INTPOL2_OUTBUF_ROUND_EN.
// ---------------------------------------------------------------------------
module tb_intpol2_iq_out_buffer;

    logic        clk;
    logic        rst_a;
    logic        clr_i;
    logic        wr_en_i;
    logic [31:0] I_in_i;
    logic [31:0] Q_in_i;
    logic        afull_o;
    logic        full_o;
    logic        empty_o;
    logic [3:0]  count_o;
    logic        ovf_o;
    logic [31:0] samples_o;

    int errors = 0;
    int checks = 0;

    intpol2_iq_out_buffer_if #(.OUT_WIDTH(16)) mIf ();

    intpol2_iq_out_buffer #(
        .DATA_WIDTH(32),
        .OUT_WIDTH (16),
        .ADDR_WIDTH(3),
        .AF_DIFF   (2)
    ) dut (
        .clk      (clk),
        .rst_a    (rst_a),
        .clr_i    (clr_i),
        .wr_en_i  (wr_en_i),
        .I_in_i   (I_in_i),
        .Q_in_i   (Q_in_i),
        .afull_o  (afull_o),
        .full_o   (full_o),
        .empty_o  (empty_o),
        .count_o  (count_o),
        .ovf_o    (ovf_o),
        .samples_o(samples_o),
        .m_if     (mIf)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then wait until the following falling edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] dI, input logic [31:0] dQ,
                                 input logic rdy, input logic clr);
        wr_en_i       = wr;
        I_in_i        = dI;
        Q_in_i        = dQ;
        mIf.m_ready_i = rdy;
        clr_i         = clr;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Global safety net against a hung simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] expI0, expQ0, expI1, expQ1;
        int          sent;
        int          got;
        logic        rdy;
        logic        wr;
        logic        stall;

`ifdef INTPOL2_OUTBUF_ROUND_EN
        expI0 = 16'h1235; expQ0 = 16'h7FFF; expI1 = 16'h8000; expQ1 = 16'h0000;
`else
        expI0 = 16'h1234; expQ0 = 16'h7FFF; expI1 = 16'h8000; expQ1 = 16'hFFFF;
`endif

        // ---------------- reset state ----------------
        rst_a = 1'b0; clr_i = 1'b0; wr_en_i = 1'b0; I_in_i = '0; Q_in_i = '0;
        mIf.m_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_valid",   32'(mIf.m_valid_o), 32'd0);
        checkOutput("rst_empty",   32'(empty_o),       32'd1);
        checkOutput("rst_count",   32'(count_o),       32'd0);
        checkOutput("rst_afull",   32'(afull_o),       32'd0);
        checkOutput("rst_full",    32'(full_o),        32'd0);
        checkOutput("rst_ovf",     32'(ovf_o),         32'd0);
        checkOutput("rst_samples", samples_o,          32'd0);
        checkOutput("rst_I",       32'(mIf.m_I_o),     32'd0);
        rst_a = 1'b1;
        @(negedge clk);

        // ---------------- narrowing ----------------
        applyStimulus(1'b1, 32'h1234C000, 32'h7FFF8000, 1'b1, 1'b0);
        checkOutput("nar_lat_valid", 32'(mIf.m_valid_o), 32'd0);
        checkOutput("nar_lat_count", 32'(count_o),       32'd1);
        checkOutput("nar_lat_empty", 32'(empty_o),       32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("nar0_valid", 32'(mIf.m_valid_o), 32'd1);
        checkOutput("nar0_I",     32'(mIf.m_I_o),     32'(expI0));
        checkOutput("nar0_Q",     32'(mIf.m_Q_o),     32'(expQ0));
        checkOutput("nar0_count", 32'(count_o),       32'd0);
        applyStimulus(1'b1, 32'h80000000, 32'hFFFF8000, 1'b1, 1'b0);
        checkOutput("nar1_hs_samples", samples_o,          32'd1);
        checkOutput("nar1_hs_valid",   32'(mIf.m_valid_o), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("nar1_I", 32'(mIf.m_I_o), 32'(expI1));
        checkOutput("nar1_Q", 32'(mIf.m_Q_o), 32'(expQ1));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("nar1_hold_valid", 32'(mIf.m_valid_o), 32'd1);
        checkOutput("nar1_hold_Q",     32'(mIf.m_Q_o),     32'(expQ1));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("nar_end_samples", samples_o,   32'd2);
        checkOutput("nar_end_empty",   32'(empty_o), 32'd1);

        // ---------------- fill and overflow ----------------
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, {16'h0100 + 16'(k), 16'h0000}, {16'h0200 + 16'(k), 16'h0000},
                          1'b0, 1'b0);
            if (k == 5) checkOutput("fill_afull_pre", 32'(afull_o), 32'd0);
            if (k == 6) begin
                checkOutput("fill_afull", 32'(afull_o), 32'd1);
                checkOutput("fill_cnt6",  32'(count_o), 32'd6);
            end
            if (k == 7) checkOutput("fill_full_pre", 32'(full_o), 32'd0);
            if (k == 8) begin
                checkOutput("fill_full",    32'(full_o),  32'd1);
                checkOutput("fill_cnt8",    32'(count_o), 32'd8);
                checkOutput("fill_ovf_pre", 32'(ovf_o),   32'd0);
            end
        end
        checkOutput("fill_ovf",   32'(ovf_o),   32'd1);
        checkOutput("fill_cnt10", 32'(count_o), 32'd8);
        for (int j = 0; j < 9; j++) begin
            checkOutput("drain_valid", 32'(mIf.m_valid_o), 32'd1);
            checkOutput("drain_I",     32'(mIf.m_I_o),     32'(16'h0100 + 16'(j)));
            checkOutput("drain_Q",     32'(mIf.m_Q_o),     32'(16'h0200 + 16'(j)));
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        checkOutput("drain_end_valid", 32'(mIf.m_valid_o), 32'd0);
        checkOutput("drain_samples",   samples_o,          32'd11);
        checkOutput("drain_ovf_stick", 32'(ovf_o),         32'd1);

        // ---------------- clear collision ----------------
        for (int k = 0; k < 10; k++)
            applyStimulus(1'b1, {16'h0300 + 16'(k), 16'h0}, {16'h0300 + 16'(k), 16'h0}, 1'b0, 1'b0);
        checkOutput("clr_pre_full", 32'(full_o), 32'd1);
        applyStimulus(1'b1, 32'hDEAD0000, 32'hBEEF0000, 1'b0, 1'b1);
        checkOutput("clr_count",   32'(count_o),       32'd0);
        checkOutput("clr_ovf",     32'(ovf_o),         32'd0);
        checkOutput("clr_samples", samples_o,          32'd0);
        checkOutput("clr_valid",   32'(mIf.m_valid_o), 32'd0);
        checkOutput("clr_full",    32'(full_o),        32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("clr_nostore_count", 32'(count_o),       32'd0);
        checkOutput("clr_nostore_valid", 32'(mIf.m_valid_o), 32'd0);

        // ---------------- ready backpressure ----------------
        sent = 0; got = 0; rdy = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            rdy   = ~rdy;
            wr    = (sent < 20) && !afull_o;
            stall = mIf.m_valid_o && !rdy;
            if (mIf.m_valid_o && rdy) begin
                checkOutput("bp_data", 32'(mIf.m_I_o), 32'(16'h0400 + 16'(got)));
                got++;
            end
            applyStimulus(wr, {16'h0400 + 16'(sent), 16'h0}, {16'h0500 + 16'(sent), 16'h0},
                          rdy, 1'b0);
            if (wr) sent++;
            if (stall) begin
                checkOutput("bp_hold_valid", 32'(mIf.m_valid_o), 32'd1);
                checkOutput("bp_hold_I",     32'(mIf.m_I_o),     32'(16'h0400 + 16'(got)));
            end
        end
        checkOutput("bp_got",     32'(got),   32'd20);
        checkOutput("bp_ovf",     32'(ovf_o), 32'd0);
        checkOutput("bp_samples", samples_o,  32'd20);

        // ---------------- streaming ----------------
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("str_clr_samples", samples_o, 32'd0);
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b1, {16'h1000 + 16'(k), 16'h0}, {16'h2000 + 16'(k), 16'h0},
                          1'b1, 1'b0);
            checkOutput("str_count_le1", 32'(count_o <= 4'd1), 32'd1);
            if (k >= 1) begin
                checkOutput("str_valid", 32'(mIf.m_valid_o), 32'd1);
                checkOutput("str_I",     32'(mIf.m_I_o),     32'(16'h1000 + 16'(k - 1)));
            end
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("str_samples99", samples_o,          32'd99);
        checkOutput("str_last_I",    32'(mIf.m_I_o),     32'h1063);
        checkOutput("str_last_v",    32'(mIf.m_valid_o), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("str_samples100", samples_o, 32'd100);

        // ---------------- reset mid-burst ----------------
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, {16'h0600 + 16'(k), 16'h0}, 32'h0, 1'b0, 1'b0);
        #2 rst_a = 1'b0;
        #1;
        checkOutput("mrst_valid",   32'(mIf.m_valid_o), 32'd0);
        checkOutput("mrst_empty",   32'(empty_o),       32'd1);
        checkOutput("mrst_count",   32'(count_o),       32'd0);
        checkOutput("mrst_samples", samples_o,          32'd0);
        checkOutput("mrst_I",       32'(mIf.m_I_o),     32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checkOutput("mrst_no_spurious", 32'(mIf.m_valid_o), 32'd0);
        end
        applyStimulus(1'b1, 32'h0ABC0000, 32'h0DEF0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("mrst_new_valid", 32'(mIf.m_valid_o), 32'd1);
        checkOutput("mrst_new_I",     32'(mIf.m_I_o),     32'h0ABC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
